// File: rtl/seq_pkg.sv
// Shared definitions for the parametrised serial-pattern detector.
// Holds the idle state, default pattern, legal pattern-width range and width helper.
package seq_pkg;

    localparam int unsigned STATE_IDLE  = 0;
    localparam logic [3:0]  DEF_PATTERN = 4'b1101;
    localparam int unsigned PAT_W_MIN   = 2;
    localparam int unsigned PAT_W_MAX   = 16;

    // What the detector does with the history at a given clock edge
    typedef enum logic [1:0] {
        ACT_HOLD,
        ACT_LOAD,
        ACT_STEP,
        ACT_RESTART
    } seq_act_e;

    function automatic int unsigned clog2w(input int unsigned n);
        int unsigned w;
        w = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < n) w = i + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/seq_prefix_match.sv
// Longest suffix of the accepted-bit history that equals a prefix of the pattern.
// One comparator per candidate length; the longest hit wins.
module seq_prefix_match
    import seq_pkg::*;
#(
    parameter int unsigned PAT_W = 4,
    localparam int unsigned SW   = clog2w(PAT_W + 1)
) (
    input  logic [PAT_W-1:0] hist,
    input  logic [SW-1:0]    hist_len,
    input  logic [PAT_W-1:0] pattern,
    output logic [SW-1:0]    match_len
);

    logic [PAT_W:1] hit;

    // Bits above hist_len are not real history, so they must not take part in a match
    for (genvar k = 1; k <= PAT_W; k++) begin : g_cmp
        assign hit[k] = (hist_len >= SW'(k)) && (hist[k-1:0] == pattern[PAT_W-1 -: k]);
    end

    always_comb begin
        match_len = '0;
        for (int unsigned k = 1; k <= PAT_W; k++) begin
            if (hit[k]) match_len = SW'(k);
        end
    end

endmodule

// File: rtl/seq_detector_param.sv
// Parametrised Moore serial-pattern detector with runtime-loadable pattern,
// overlap/non-overlap mode, input-valid gating and a saturating match counter.
module seq_detector_param
    import seq_pkg::*;
#(
    parameter int unsigned      PAT_W   = 4,
    parameter logic [PAT_W-1:0] PATTERN = PAT_W'(DEF_PATTERN),
    parameter int unsigned      CNT_W   = 8,
    localparam int unsigned     SW      = clog2w(PAT_W + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             entrada,
    input  logic             en,
    input  logic             overlap,
    input  logic             pat_load,
    input  logic [PAT_W-1:0] pat_in,
    input  logic             count_clr,
    output logic             salida,
    output logic [SW-1:0]    estado,
    output logic [CNT_W-1:0] match_count
);

    localparam logic [SW-1:0] ST_MATCH = SW'(PAT_W);
    localparam logic [SW-1:0] ST_IDLE  = SW'(STATE_IDLE);

    logic [PAT_W-1:0] pattern_q, pattern_d;
    logic [PAT_W-1:0] hist_q, hist_d;
    logic [SW-1:0]    len_q, len_d;
    logic [SW-1:0]    state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;

    seq_act_e         act;
    logic [PAT_W-1:0] step_hist;
    logic [SW-1:0]    step_len;
    logic [SW-1:0]    step_state;
    logic             hit;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pattern_q <= PATTERN;
            hist_q    <= '0;
            len_q     <= '0;
            state_q   <= ST_IDLE;
            count_q   <= '0;
        end else begin
            pattern_q <= pattern_d;
            hist_q    <= hist_d;
            len_q     <= len_d;
            state_q   <= state_d;
            count_q   <= count_d;
        end
    end

    // Non-overlap mode restarts the history only when leaving the match state
    always_comb begin
        act = ACT_HOLD;
        if (pat_load) begin
            act = ACT_LOAD;
        end else if (en) begin
            act = (state_q == ST_MATCH && !overlap) ? ACT_RESTART : ACT_STEP;
        end
    end

    always_comb begin
        step_hist = '0;
        step_len  = '0;
        unique case (act)
            ACT_STEP: begin
                step_hist = {hist_q[PAT_W-2:0], entrada};
                step_len  = (len_q == ST_MATCH) ? len_q : len_q + SW'(1);
            end
            ACT_RESTART: begin
                step_hist = {{(PAT_W-1){1'b0}}, entrada};
                step_len  = SW'(1);
            end
            ACT_HOLD, ACT_LOAD: begin
                step_hist = '0;
                step_len  = '0;
            end
        endcase
    end

    seq_prefix_match #(
        .PAT_W(PAT_W)
    ) u_match (
        .hist      (step_hist),
        .hist_len  (step_len),
        .pattern   (pattern_q),
        .match_len (step_state)
    );

    always_comb begin
        pattern_d = pattern_q;
        hist_d    = hist_q;
        len_d     = len_q;
        state_d   = state_q;
        hit       = 1'b0;
        unique case (act)
            ACT_LOAD: begin
                pattern_d = pat_in;
                hist_d    = '0;
                len_d     = '0;
                state_d   = ST_IDLE;
            end
            ACT_STEP, ACT_RESTART: begin
                hist_d  = step_hist;
                len_d   = step_len;
                state_d = step_state;
                hit     = (step_state == ST_MATCH);
            end
            ACT_HOLD: begin
                state_d = state_q;
            end
        endcase
    end

    // A clear coinciding with a new match keeps that match
    always_comb begin
        count_d = count_q;
        if (hit && count_clr) begin
            count_d = CNT_W'(1);
        end else if (count_clr) begin
            count_d = '0;
        end else if (hit && count_q != '1) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    assign salida      = (state_q == ST_MATCH);
    assign estado      = state_q;
    assign match_count = count_q;

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed scoreboard bench for seq_detector_param: three instances (default,
// PATTERN=1010, CNT_W=2) share one stimulus stream; each step checks one instance.
module tb_seq_detector_param;

    logic       clk;
    logic       reset;
    logic       entrada;
    logic       en;
    logic       overlap;
    logic       pat_load;
    logic [3:0] pat_in;
    logic       count_clr;

    logic       sal_a, sal_b, sal_c;
    logic [2:0] est_a, est_b, est_c;
    logic [7:0] cnt_a, cnt_b;
    logic [1:0] cnt_c;

    seq_detector_param dut_a (
        .clk(clk), .reset(reset), .entrada(entrada), .en(en), .overlap(overlap),
        .pat_load(pat_load), .pat_in(pat_in), .count_clr(count_clr),
        .salida(sal_a), .estado(est_a), .match_count(cnt_a)
    );

    seq_detector_param #(.PATTERN(4'b1010)) dut_b (
        .clk(clk), .reset(reset), .entrada(entrada), .en(en), .overlap(overlap),
        .pat_load(pat_load), .pat_in(pat_in), .count_clr(count_clr),
        .salida(sal_b), .estado(est_b), .match_count(cnt_b)
    );

    seq_detector_param #(.CNT_W(2)) dut_c (
        .clk(clk), .reset(reset), .entrada(entrada), .en(en), .overlap(overlap),
        .pat_load(pat_load), .pat_in(pat_in), .count_clr(count_clr),
        .salida(sal_c), .estado(est_c), .match_count(cnt_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        int unsigned dut;
        int          est;
        int          cnt;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;

    function automatic int obs_est(input int unsigned d);
        case (d)
            0:       return int'(est_a);
            1:       return int'(est_b);
            default: return int'(est_c);
        endcase
    endfunction

    function automatic int obs_sal(input int unsigned d);
        case (d)
            0:       return int'(sal_a);
            1:       return int'(sal_b);
            default: return int'(sal_c);
        endcase
    endfunction

    function automatic int obs_cnt(input int unsigned d);
        case (d)
            0:       return int'(cnt_a);
            1:       return int'(cnt_b);
            default: return int'(cnt_c);
        endcase
    endfunction

    task automatic chk(input string tag, input int observed, input int expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic push(input string tag, input int unsigned d, input int est, input int cnt);
        exp_t x;
        x.tag = tag;
        x.dut = d;
        x.est = est;
        x.cnt = cnt;
        sbq.push_back(x);
    endtask

    task automatic check_front();
        exp_t x;
        if (sbq.size() == 0) begin
            chk("scoreboard_empty", 1, 0);
        end else begin
            x = sbq.pop_front();
            chk({x.tag, ".estado"}, obs_est(x.dut), x.est);
            chk({x.tag, ".salida"}, obs_sal(x.dut), (x.est == 4) ? 1 : 0);
            chk({x.tag, ".count"},  obs_cnt(x.dut), x.cnt);
        end
    endtask

    // Drive one bit, record the expected post-edge state, then compare after the edge
    task automatic step(input string tag, input int unsigned d, input logic b, input logic e,
                        input int est, input int cnt);
        entrada = b;
        en      = e;
        push(tag, d, est, cnt);
        @(posedge clk);
        #1;
        check_front();
        pat_load  = 1'b0;
        count_clr = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #2;
        reset = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset     = 1'b0;
        entrada   = 1'b0;
        en        = 1'b0;
        overlap   = 1'b1;
        pat_load  = 1'b0;
        pat_in    = 4'b0000;
        count_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.estado_a", int'(est_a), 0);
        chk("rst.salida_a", int'(sal_a), 0);
        chk("rst.count_a",  int'(cnt_a), 0);
        chk("rst.count_c",  int'(cnt_c), 0);
        reset = 1'b1;

        // Default 1101, overlapping
        step("t1.b1", 0, 1'b1, 1'b1, 1, 0);
        step("t1.b2", 0, 1'b1, 1'b1, 2, 0);
        step("t1.b3", 0, 1'b0, 1'b1, 3, 0);
        step("t1.b4", 0, 1'b1, 1'b1, 4, 1);
        step("t1.b5", 0, 1'b1, 1'b1, 2, 1);
        step("t1.b6", 0, 1'b0, 1'b1, 3, 1);
        step("t1.b7", 0, 1'b1, 1'b1, 4, 2);

        // PATTERN=1010, overlapping then non-overlapping
        do_reset();
        step("t2o.b1", 1, 1'b1, 1'b1, 1, 0);
        step("t2o.b2", 1, 1'b0, 1'b1, 2, 0);
        step("t2o.b3", 1, 1'b1, 1'b1, 3, 0);
        step("t2o.b4", 1, 1'b0, 1'b1, 4, 1);
        step("t2o.b5", 1, 1'b1, 1'b1, 3, 1);
        step("t2o.b6", 1, 1'b0, 1'b1, 4, 2);
        do_reset();
        overlap = 1'b0;
        step("t2n.b1", 1, 1'b1, 1'b1, 1, 0);
        step("t2n.b2", 1, 1'b0, 1'b1, 2, 0);
        step("t2n.b3", 1, 1'b1, 1'b1, 3, 0);
        step("t2n.b4", 1, 1'b0, 1'b1, 4, 1);
        step("t2n.b5", 1, 1'b1, 1'b1, 1, 1);
        step("t2n.b6", 1, 1'b0, 1'b1, 2, 1);
        overlap = 1'b1;

        // en=0 gap with toggling entrada
        do_reset();
        step("t3.b1",  0, 1'b1, 1'b1, 1, 0);
        step("t3.b2",  0, 1'b1, 1'b1, 2, 0);
        step("t3.gap1", 0, 1'b0, 1'b0, 2, 0);
        step("t3.gap2", 0, 1'b1, 1'b0, 2, 0);
        step("t3.gap3", 0, 1'b0, 1'b0, 2, 0);
        step("t3.b3",  0, 1'b0, 1'b1, 3, 0);
        step("t3.b4",  0, 1'b1, 1'b1, 4, 1);

        // Runtime pattern load overrides en in the same cycle
        do_reset();
        step("t4.b1", 0, 1'b1, 1'b1, 1, 0);
        step("t4.b2", 0, 1'b1, 1'b1, 2, 0);
        pat_load = 1'b1;
        pat_in   = 4'b0110;
        step("t4.load", 0, 1'b0, 1'b1, 0, 0);
        step("t4.p1", 0, 1'b0, 1'b1, 1, 0);
        step("t4.p2", 0, 1'b1, 1'b1, 2, 0);
        step("t4.p3", 0, 1'b1, 1'b1, 3, 0);
        step("t4.p4", 0, 1'b0, 1'b1, 4, 1);

        // Async reset mid-cycle while matched on the loaded pattern
        reset = 1'b0;
        #2;
        chk("t5.estado", int'(est_a), 0);
        chk("t5.salida", int'(sal_a), 0);
        chk("t5.count",  int'(cnt_a), 0);
        reset = 1'b1;
        step("t5.r1", 0, 1'b1, 1'b1, 1, 0);
        step("t5.r2", 0, 1'b1, 1'b1, 2, 0);
        step("t5.r3", 0, 1'b0, 1'b1, 3, 0);
        step("t5.r4", 0, 1'b1, 1'b1, 4, 1);

        // CNT_W=2 saturation, then clear colliding with a match
        do_reset();
        step("t6.m1a", 2, 1'b1, 1'b1, 1, 0);
        step("t6.m1b", 2, 1'b1, 1'b1, 2, 0);
        step("t6.m1c", 2, 1'b0, 1'b1, 3, 0);
        step("t6.m1d", 2, 1'b1, 1'b1, 4, 1);
        for (int m = 2; m <= 5; m++) begin
            step("t6.ma", 2, 1'b1, 1'b1, 2, (m - 1 > 3) ? 3 : m - 1);
            step("t6.mb", 2, 1'b0, 1'b1, 3, (m - 1 > 3) ? 3 : m - 1);
            step("t6.mc", 2, 1'b1, 1'b1, 4, (m > 3) ? 3 : m);
        end
        chk("t6.wide_count", int'(cnt_a), 5);
        step("t6.ca", 2, 1'b1, 1'b1, 2, 3);
        step("t6.cb", 2, 1'b0, 1'b1, 3, 3);
        count_clr = 1'b1;
        step("t6.clr_match", 2, 1'b1, 1'b1, 4, 1);
        count_clr = 1'b1;
        step("t6.clr_only", 2, 1'b1, 1'b1, 2, 0);

        chk("sb_drained", sbq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
